// File: rtl/exttrg_pulser.sv
// Avalon-MM trigger output block: static levels, programmable one-shot pulses,
// a periodic auto-trigger and a saturating count of fire events.
module exttrg_pulser #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 16,
    parameter int PER_W       = 24,
    parameter int DEFAULT_LEN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_FIRE   = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_MASK   = 3'd3;
    localparam logic [2:0] A_PERIOD = 3'd4;
    localparam logic [2:0] A_COUNT  = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [CNT_W-1:0] len_q,    len_d;
    logic [WIDTH-1:0] mask_q,   mask_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] pctr_q,   pctr_d;
    logic [31:0]      count_q,  count_d;

    logic             auto_fire;
    logic [WIDTH-1:0] manual_set;
    logic [WIDTH-1:0] fire_set;
    logic [WIDTH-1:0] busy;
    logic [CNT_W-1:0] len_eff;

    // Every writedata bit is consumed somewhere only when the widths are 32.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    assign auto_fire  = (period_q != '0) && (pctr_q == period_q - PER_W'(1));
    assign manual_set = (wr_en && address == A_FIRE) ? writedata[WIDTH-1:0] : '0;
    assign fire_set   = manual_set | (auto_fire ? mask_q : '0);
    assign len_eff    = (len_q == '0) ? CNT_W'(1) : len_q;

    always_comb begin
        data_d   = data_q;
        len_d    = len_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (address)
                A_DATA:   data_d   = writedata[WIDTH-1:0];
                A_LEN:    len_d    = writedata[CNT_W-1:0];
                A_MASK:   mask_d   = writedata[WIDTH-1:0];
                A_PERIOD: period_d = writedata[PER_W-1:0];
                default:  ;
            endcase
        end
    end

    // A PERIOD write restarts the phase so the first fire lands PERIOD cycles later.
    always_comb begin
        pctr_d = pctr_q + PER_W'(1);
        if (wr_en && address == A_PERIOD) begin
            pctr_d = '0;
        end else if (period_q == '0 || auto_fire) begin
            pctr_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && address == A_COUNT) begin
            count_d = '0;
        end else if (fire_set != '0 && count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            len_q    <= CNT_W'(DEFAULT_LEN);
            mask_q   <= '0;
            period_q <= '0;
            pctr_q   <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            len_q    <= len_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            pctr_q   <= pctr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [CNT_W-1:0] pcnt_q, pcnt_d;

            // A fire on a busy channel simply reloads, extending the pulse gaplessly.
            always_comb begin
                pcnt_d = pcnt_q;
                if (fire_set[gi]) begin
                    pcnt_d = len_eff;
                end else if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end

            assign busy[gi] = (pcnt_q != '0);
        end
    endgenerate

    assign out_port = data_q | busy;

    always_comb begin
        readdata = 32'd0;
        case (address)
            A_DATA:   readdata = 32'(data_q);
            A_FIRE:   readdata = 32'(busy);
            A_LEN:    readdata = 32'(len_q);
            A_MASK:   readdata = 32'(mask_q);
            A_PERIOD: readdata = 32'(period_q);
            A_COUNT:  readdata = count_q;
            default:  readdata = 32'd0;
        endcase
    end

endmodule
